apb_master_8bit: RTL and testbench

APB initiator that turns a simple valid/ready command stream into single APB3 transfers toward the 8-bit timer counter register file, or any peripheral on the same bus. It runs the IDLE/SETUP/ACCESS phases, honours `pready` wait states and captures `prdata`/`pslverr`. It also aborts transfers that stall past a programmable wait-state limit. It replaces hand-written bus stimulus and is the bus driver for the timer in system-level integration.

---
 rtl/apb_master_8bit_if.sv | 40 ++++
 rtl/apb_master_8bit.sv | 148 ++++++++++++++
 tb/tb_apb_master_8bit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_8bit_if.sv
// Command-stream and APB3 bus signals of the 8-bit APB initiator.
// The master modport is the initiator's view; slave is the command source plus peripheral.
interface apb_master_8bit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_8bit.sv
// APB3 initiator: one valid/ready command becomes one APB transfer, with a
// wait-state limit that aborts stalled transfers. All outputs are registered.
//   state    | meaning
//   S_IDLE   | cmd_ready high, waiting for a command
//   S_SETUP  | psel high, penable low, address/data presented
//   S_ACCESS | psel and penable high, waiting for pready or the wait limit
module apb_master_8bit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                pclk,
  input  logic                preset_n,
  apb_master_8bit_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= 8'd0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = S_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
        end
      end

      S_SETUP: begin
        state_d    = S_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = 8'd0;
      end

      S_ACCESS: begin
        // pready wins over the wait limit when both land on the same edge
        if (bus.pready) begin
          state_d       = S_IDLE;
          cmd_ready_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
        end else if (TO_EN && (wait_cnt_q == TO_LAST)) begin
          state_d       = S_IDLE;
          cmd_ready_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_8bit.sv
// Bench for apb_master_8bit (TIMEOUT=4): a transaction-timeline model predicts every
// output each cycle, and literal checks pin latencies, wait counts and response values.
module tb_apb_master_8bit;

  localparam int TO = 4;

  logic pclk;
  logic preset_n;

  apb_master_8bit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  apb_master_8bit #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(TO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected outputs, maintained by the transaction driver
  logic       e_cmd_ready, e_psel, e_pen, e_pwrite, e_rv, e_err, e_to;
  logic [2:0] e_paddr;
  logic [7:0] e_pwdata, e_rdata;

  int cyc = 0;
  int psel_cycles = 0;
  int pen_cycles  = 0;
  int rv_seen     = 0;

  always @(posedge pclk) cyc++;

  always @(negedge pclk) begin
    chk("cmd_ready",   bus.cmd_ready,   e_cmd_ready);
    chk("psel",        bus.psel,        e_psel);
    chk("penable",     bus.penable,     e_pen);
    chk("pwrite",      bus.pwrite,      e_pwrite);
    chk("paddr",       bus.paddr,       e_paddr);
    chk("pwdata",      bus.pwdata,      e_pwdata);
    chk("rsp_valid",   bus.rsp_valid,   e_rv);
    chk("rsp_rdata",   bus.rsp_rdata,   e_rdata);
    chk("rsp_err",     bus.rsp_err,     e_err);
    chk("rsp_timeout", bus.rsp_timeout, e_to);
    if (bus.psel)      psel_cycles++;
    if (bus.penable)   pen_cycles++;
    if (bus.rsp_valid) rv_seen++;
  end

  task automatic exp_reset();
    e_cmd_ready = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_pwrite = 1'b0;
    e_paddr = 3'd0; e_pwdata = 8'd0; e_rv = 1'b0; e_rdata = 8'd0;
    e_err = 1'b0; e_to = 1'b0;
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    int         waits;  // pready-low ACCESS cycles before pready rises
    logic [7:0] rdata;
    bit         serr;   // pslverr on the completing edge
    bit         noise;  // pslverr during wait cycles
  } txn_t;

  txn_t q[$];
  int   acc_log[$];

  int         last_lat, last_psel, last_pen;
  logic [7:0] last_rdata;
  logic       last_err, last_to, last_rv;

  task automatic push(input bit wr, input logic [2:0] addr, input logic [7:0] wdata,
                      input int waits, input logic [7:0] rdata, input bit serr, input bit noise);
    txn_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.waits = waits;
    t.rdata = rdata; t.serr = serr; t.noise = noise;
    q.push_back(t);
  endtask

  task automatic present(input txn_t t);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = t.wr;
    bus.cmd_addr  = t.addr;
    bus.cmd_wdata = t.wdata;
  endtask

  // Runs every queued transaction; called just after a rising edge with the DUT idle.
  task automatic run_queue(input bit b2b);
    txn_t t;
    int   acc_cycles;
    bit   tmo;
    int   lat;
    while (q.size() > 0) begin
      t = q.pop_front();
      present(t);
      psel_cycles = 0;
      pen_cycles  = 0;
      @(posedge pclk); #1;
      acc_log.push_back(cyc);
      lat = 1;
      if (b2b && q.size() > 0) present(q[0]);
      else begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~t.wr;
        bus.cmd_addr  = ~t.addr;
        bus.cmd_wdata = ~t.wdata;
      end
      e_cmd_ready = 1'b0; e_psel = 1'b1; e_pen = 1'b0; e_rv = 1'b0;
      e_pwrite = t.wr; e_paddr = t.addr; e_pwdata = t.wdata;

      tmo        = (TO != 0) && (t.waits >= TO);
      acc_cycles = tmo ? TO : t.waits + 1;

      // SETUP ignores pready/pslverr entirely
      bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 8'hEE;
      @(posedge pclk); #1;
      lat++;
      e_pen = 1'b1;

      for (int j = 1; j <= acc_cycles; j++) begin
        if (j <= t.waits) begin
          bus.pready = 1'b0; bus.pslverr = t.noise; bus.prdata = 8'hA5 ^ 8'(j);
        end else begin
          bus.pready = 1'b1; bus.pslverr = t.serr; bus.prdata = t.rdata;
        end
        @(posedge pclk); #1;
        lat++;
      end
      bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 8'h00;

      e_cmd_ready = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b1;
      e_rdata = (tmo || t.wr) ? 8'h00 : t.rdata;
      e_err   = tmo || t.serr;
      e_to    = tmo;

      last_lat   = lat;
      last_psel  = psel_cycles;
      last_pen   = pen_cycles;
      last_rv    = bus.rsp_valid;
      last_rdata = bus.rsp_rdata;
      last_err   = bus.rsp_err;
      last_to    = bus.rsp_timeout;

      if (!(b2b && q.size() > 0)) begin
        @(posedge pclk); #1;
        e_rv = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int rv_before;

  initial begin
    exp_reset();
    preset_n      = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_wdata = 8'd0;
    bus.pready    = 1'b0; bus.pslverr = 1'b0; bus.prdata = 8'd0;
    #12;
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_psel",      bus.psel,      0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    #10 preset_n = 1'b1;
    @(posedge pclk); #1;

    // write 0x5A to 2, no wait states
    push(1'b1, 3'd2, 8'h5A, 0, 8'h00, 1'b0, 1'b0);
    run_queue(1'b0);
    chk("wr_latency",   last_lat,   3);
    chk("wr_psel_cyc",  last_psel,  2);
    chk("wr_pen_cyc",   last_pen,   1);
    chk("wr_rsp_valid", last_rv,    1);
    chk("wr_rsp_rdata", last_rdata, 8'h00);
    chk("wr_rsp_err",   last_err,   0);
    chk("wr_paddr",     bus.paddr,  3'd2);
    chk("wr_pwdata",    bus.pwdata, 8'h5A);

    // read 3 with two wait states
    push(1'b0, 3'd3, 8'h00, 2, 8'h81, 1'b0, 1'b0);
    run_queue(1'b0);
    chk("rd_latency",   last_lat,   5);
    chk("rd_pen_cyc",   last_pen,   3);
    chk("rd_rsp_rdata", last_rdata, 8'h81);
    chk("rd_rsp_err",   last_err,   0);

    // slave error on completion
    push(1'b1, 3'd7, 8'h11, 0, 8'h00, 1'b1, 1'b0);
    run_queue(1'b0);
    chk("slverr_err", last_err, 1);
    chk("slverr_to",  last_to,  0);

    // slave error only during wait states is ignored
    push(1'b1, 3'd7, 8'h22, 2, 8'h00, 1'b0, 1'b1);
    run_queue(1'b0);
    chk("noise_err", last_err, 0);
    chk("noise_lat", last_lat, 5);

    // pready never comes: abort after TO access cycles
    push(1'b0, 3'd1, 8'h00, 50, 8'h99, 1'b0, 1'b1);
    run_queue(1'b0);
    chk("to_latency", last_lat,   TO + 2);
    chk("to_pen_cyc", last_pen,   4);
    chk("to_valid",   last_rv,    1);
    chk("to_err",     last_err,   1);
    chk("to_flag",    last_to,    1);
    chk("to_rdata",   last_rdata, 8'h00);

    // pready rises on the last allowed access cycle: normal completion
    push(1'b0, 3'd5, 8'h00, 3, 8'h3C, 1'b0, 1'b0);
    run_queue(1'b0);
    chk("edge_latency", last_lat,   6);
    chk("edge_pen_cyc", last_pen,   4);
    chk("edge_to",      last_to,    0);
    chk("edge_err",     last_err,   0);
    chk("edge_rdata",   last_rdata, 8'h3C);

    // four commands back to back with cmd_valid held high
    acc_log.delete();
    rv_before = rv_seen;
    push(1'b1, 3'd1, 8'h10, 0, 8'h00, 1'b0, 1'b0);
    push(1'b0, 3'd4, 8'h00, 0, 8'hC4, 1'b0, 1'b0);
    push(1'b1, 3'd6, 8'h66, 0, 8'h00, 1'b0, 1'b0);
    push(1'b0, 3'd2, 8'h00, 0, 8'h7E, 1'b0, 1'b0);
    run_queue(1'b1);
    for (int k = 1; k < 4; k++) chk("b2b_spacing", acc_log[k] - acc_log[k-1], 3);
    chk("b2b_rv_count", rv_seen - rv_before, 4);
    chk("b2b_last_rdata", last_rdata, 8'h7E);

    // reset asserted in the middle of ACCESS
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 3'd6; bus.cmd_wdata = 8'h00;
    bus.pready = 1'b0;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    e_cmd_ready = 1'b0; e_psel = 1'b1; e_pen = 1'b0;
    e_pwrite = 1'b0; e_paddr = 3'd6; e_pwdata = 8'h00;
    @(posedge pclk); #1;
    e_pen = 1'b1;
    @(posedge pclk); #1;
    #2;
    preset_n = 1'b0;
    exp_reset();
    #1;
    chk("arst_psel",      bus.psel,      0);
    chk("arst_penable",   bus.penable,   0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_paddr",     bus.paddr,     3'd0);
    chk("arst_rsp_rdata", bus.rsp_rdata, 8'h00);
    rv_before = rv_seen;
    @(posedge pclk);
    @(posedge pclk);
    #3 preset_n = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    chk("arst_no_rsp", rv_seen - rv_before, 0);

    push(1'b0, 3'd6, 8'h00, 1, 8'h5C, 1'b0, 1'b0);
    run_queue(1'b0);
    chk("post_rst_latency", last_lat,   4);
    chk("post_rst_rdata",   last_rdata, 8'h5C);

    @(posedge pclk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
